// File: rtl/lbsmm_pkg.sv
// Shared field widths, product decode helper and sequencer states for the LBSMM
// dot-product datapath.
package lbsmm_pkg;

  localparam int SM_W          = 4;
  localparam int SM_SIGN_BIT   = 3;
  localparam int MAG_W         = 3;
  localparam int PROD_W        = 7;
  localparam int PROD_SIGN_BIT = 6;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Sign-magnitude product to two's complement, masked to 'width' bits.
  // A zero magnitude maps to 0 whatever its sign bit says.
  function automatic logic [31:0] sm7_to_tc(input logic [PROD_W-1:0] prod, input int width);
    logic [31:0] mag;
    logic [31:0] tc;
    logic [31:0] mask;
    mag  = {26'd0, prod[PROD_SIGN_BIT-1:0]};
    tc   = (prod[PROD_SIGN_BIT] && (mag != 32'd0)) ? (32'd0 - mag) : mag;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return tc & mask;
  endfunction

endpackage

// File: rtl/lbsmm.sv
// 4-bit sign-magnitude multiplier producing a 7-bit sign-magnitude product.
// Purely combinational; no handshake.
module lbsmm
  import lbsmm_pkg::*;
(
  input  logic [SM_W-1:0]   a,
  input  logic [SM_W-1:0]   b,
  output logic [PROD_W-1:0] p
);

  assign p = {a[SM_SIGN_BIT] ^ b[SM_SIGN_BIT],
              {3'b000, a[MAG_W-1:0]} * {3'b000, b[MAG_W-1:0]}};

endmodule

// File: rtl/lbsmm_dot_ctrl.sv
// Streams SM operand pairs through one LBSMM and accumulates a dot product.
// Last beat accepted at edge k -> out_valid after edge k+2; result held until out_ready.
module lbsmm_dot_ctrl
  import lbsmm_pkg::*;
#(
  parameter int ACC_W   = 16,
  parameter int MAX_LEN = 64,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  state_t             state_q, state_d;
  logic [SM_W-1:0]    op_a_q, op_a_d;
  logic [SM_W-1:0]    op_b_q, op_b_d;
  logic               op_vld_q, op_vld_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;

  logic [PROD_W-1:0]  prod;
  logic [ACC_W-1:0]   prod_tc;
  logic [ACC_W-1:0]   sum;
  logic               add_ovf;
  logic               accept;
  logic [CNT_W:0]     nxt_beats;
  logic               cap;

  lbsmm u_lbsmm (
    .a (op_a_q),
    .b (op_b_q),
    .p (prod)
  );

  always_comb begin
    prod_tc = ACC_W'(sm7_to_tc(prod, ACC_W));
    sum     = acc_q + prod_tc;
    add_ovf = (acc_q[ACC_W-1] == prod_tc[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
  end

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_vld_d    = 1'b0;
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    in_ready    = (state_q == ACCUM);
    accept      = in_valid && in_ready;
    // Beats accepted so far includes the one still sitting in the operand register.
    nxt_beats   = {1'b0, count_q} + {{CNT_W{1'b0}}, op_vld_q} + (CNT_W+1)'(1);
    cap         = (nxt_beats == (CNT_W+1)'(MAX_LEN));

    if (accept) begin
      op_a_d   = in_a;
      op_b_d   = in_b;
      op_vld_d = 1'b1;
    end

    if (op_vld_q) begin
      acc_d   = sum;
      count_d = count_q + CNT_W'(1);
      if (add_ovf) ovf_d = 1'b1;
    end

    case (state_q)
      ACCUM: begin
        if (accept && (in_last || cap)) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_sum_d   = acc_q;
          out_count_d = count_q;
          out_ovf_d   = ovf_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          count_d     = '0;
          ovf_d       = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_vld_q    <= 1'b0;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_vld_q    <= op_vld_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_lbsmm_dot_ctrl.sv
// Directed bench for lbsmm_dot_ctrl: three instances (default, MAX_LEN=8, ACC_W=8)
// share one input stream; each scenario resets all and checks the relevant instance.
module tb_lbsmm_dot_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       in_last;
  logic       out_ready;

  logic        rdy0, ov0, ovf0;
  logic [15:0] sum0;
  logic [6:0]  cnt0;
  logic        rdy1, ov1, ovf1;
  logic [15:0] sum1;
  logic [3:0]  cnt1;
  logic        rdy2, ov2, ovf2;
  logic [7:0]  sum2;
  logic [6:0]  cnt2;

  logic [2:0] rdy_v;
  logic [2:0] ov_v;
  assign rdy_v = {rdy2, rdy1, rdy0};
  assign ov_v  = {ov2, ov1, ov0};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lbsmm_dot_ctrl #(.ACC_W(16), .MAX_LEN(64)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(ov0), .out_ready(out_ready), .out_sum(sum0),
    .out_count(cnt0), .out_ovf(ovf0));

  lbsmm_dot_ctrl #(.ACC_W(16), .MAX_LEN(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(ov1), .out_ready(out_ready), .out_sum(sum1),
    .out_count(cnt1), .out_ovf(ovf1));

  lbsmm_dot_ctrl #(.ACC_W(8), .MAX_LEN(64)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(ov2), .out_ready(out_ready), .out_sum(sum2),
    .out_count(cnt2), .out_ovf(ovf2));

  task automatic reset_all();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_last   = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one beat and returns at the negedge right after it is accepted.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic last, input int sel);
    int n;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    n = 0;
    while (!rdy_v[sel] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_v[sel]) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready of u%0d still %b, required 1", sel, rdy_v[sel]);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int sel);
    int n;
    n = 0;
    while (!ov_v[sel] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ov_v[sel]) begin
      checks++; errors++;
      $display("FAIL out_timeout: out_valid of u%0d still %b, required 1", sel, ov_v[sel]);
    end
  endtask

  task automatic handshake(input int sel);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (ov_v[sel] !== 1'b0) begin
      errors++; $display("FAIL hs_clear: u%0d out_valid=%b required 0", sel, ov_v[sel]);
    end
  endtask

  task automatic test_reset();
    reset_all();
    checks++;
    if (rdy_v !== 3'b111) begin errors++; $display("FAIL rst_ready: got %b required 111", rdy_v); end
    checks++;
    if (ov_v !== 3'b000) begin errors++; $display("FAIL rst_valid: got %b required 000", ov_v); end
    checks++;
    if (sum0 !== 16'h0 || cnt0 !== 7'd0 || ovf0 !== 1'b0) begin
      errors++; $display("FAIL rst_outs: sum=%h cnt=%0d ovf=%b required 0/0/0", sum0, cnt0, ovf0);
    end
  endtask

  task automatic test_single_beat();
    reset_all();
    send(4'b1011, 4'b0101, 1'b1, 0);
    checks++;
    if (ov0 !== 1'b0) begin errors++; $display("FAIL single_lat_k: out_valid=%b required 0", ov0); end
    @(negedge clk);
    checks++;
    if (ov0 !== 1'b0) begin errors++; $display("FAIL single_lat_k1: out_valid=%b required 0", ov0); end
    @(negedge clk);
    checks++;
    if (ov0 !== 1'b1) begin errors++; $display("FAIL single_lat_k2: out_valid=%b required 1", ov0); end
    checks++;
    if (sum0 !== 16'hFFF1) begin errors++; $display("FAIL single_sum: got %h required fff1", sum0); end
    checks++;
    if (cnt0 !== 7'd1 || ovf0 !== 1'b0) begin
      errors++; $display("FAIL single_cnt_ovf: cnt=%0d ovf=%b required 1/0", cnt0, ovf0);
    end
    handshake(0);
  endtask

  task automatic test_four_beat();
    reset_all();
    send(4'b0111, 4'b0111, 1'b0, 0);
    send(4'b1111, 4'b0111, 1'b0, 0);
    send(4'b0010, 4'b1011, 1'b0, 0);
    send(4'b1000, 4'b0101, 1'b1, 0);
    wait_out(0);
    checks++;
    if (sum0 !== 16'hFFFA) begin errors++; $display("FAIL four_sum: got %h required fffa", sum0); end
    checks++;
    if (cnt0 !== 7'd4) begin errors++; $display("FAIL four_cnt: got %0d required 4", cnt0); end
    handshake(0);
  endtask

  task automatic test_max_len();
    reset_all();
    for (int i = 0; i < 8; i++) send(4'b0111, 4'b0111, 1'b0, 1);
    checks++;
    if (rdy1 !== 1'b0) begin errors++; $display("FAIL cap_ready_drop: in_ready=%b required 0", rdy1); end
    in_a = 4'b0111; in_b = 4'b0111; in_last = 1'b1; in_valid = 1'b1;
    wait_out(1);
    checks++;
    if (sum1 !== 16'd392) begin errors++; $display("FAIL cap_sum: got %0d required 392", sum1); end
    checks++;
    if (cnt1 !== 4'd8 || rdy1 !== 1'b0) begin
      errors++; $display("FAIL cap_cnt: cnt=%0d in_ready=%b required 8/0", cnt1, rdy1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (rdy1 !== 1'b1) begin errors++; $display("FAIL cap_resume: in_ready=%b required 1", rdy1); end
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(1);
    checks++;
    if (sum1 !== 16'd49 || cnt1 !== 4'd1) begin
      errors++; $display("FAIL cap_next_vec: sum=%0d cnt=%0d required 49/1", sum1, cnt1);
    end
    handshake(1);
  endtask

  task automatic test_overflow();
    reset_all();
    send(4'b0111, 4'b0111, 1'b0, 2);
    send(4'b0111, 4'b0111, 1'b0, 2);
    send(4'b0111, 4'b0111, 1'b1, 2);
    wait_out(2);
    checks++;
    if (sum2 !== 8'h93) begin errors++; $display("FAIL ovf_sum: got %h required 93", sum2); end
    checks++;
    if (ovf2 !== 1'b1 || cnt2 !== 7'd3) begin
      errors++; $display("FAIL ovf_flag: ovf=%b cnt=%0d required 1/3", ovf2, cnt2);
    end
    handshake(2);
    send(4'b0001, 4'b0001, 1'b1, 2);
    wait_out(2);
    checks++;
    if (sum2 !== 8'h01 || ovf2 !== 1'b0) begin
      errors++; $display("FAIL ovf_cleared: sum=%h ovf=%b required 01/0", sum2, ovf2);
    end
    handshake(2);
  endtask

  task automatic test_back_to_back();
    reset_all();
    send(4'b0001, 4'b0010, 1'b1, 0);
    wait_out(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (ov0 !== 1'b1 || sum0 !== 16'd2 || cnt0 !== 7'd1 || rdy0 !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b sum=%0d cnt=%0d rdy=%b required 1/2/1/0",
                 i, ov0, sum0, cnt0, rdy0);
      end
    end
    in_a = 4'b0011; in_b = 4'b0011; in_last = 1'b1; in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (ov0 !== 1'b0 || rdy0 !== 1'b1) begin
      errors++; $display("FAIL bp_release: valid=%b rdy=%b required 0/1", ov0, rdy0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (rdy0 !== 1'b0) begin errors++; $display("FAIL bp_next_accept: rdy=%b required 0", rdy0); end
    wait_out(0);
    checks++;
    if (sum0 !== 16'd9 || cnt0 !== 7'd1) begin
      errors++; $display("FAIL bp_next_sum: sum=%0d cnt=%0d required 9/1", sum0, cnt0);
    end
    handshake(0);
  endtask

  task automatic test_mid_reset();
    reset_all();
    for (int i = 0; i < 3; i++) send(4'b0010, 4'b0010, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (ov0 !== 1'b0 || rdy0 !== 1'b1) begin
      errors++; $display("FAIL mid_rst_state: valid=%b rdy=%b required 0/1", ov0, rdy0);
    end
    send(4'b0001, 4'b1001, 1'b1, 0);
    wait_out(0);
    checks++;
    if (sum0 !== 16'hFFFF || cnt0 !== 7'd1 || ovf0 !== 1'b0) begin
      errors++; $display("FAIL mid_rst_vec: sum=%h cnt=%0d ovf=%b required ffff/1/0", sum0, cnt0, ovf0);
    end
    handshake(0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = 4'h0; in_b = 4'h0; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_beat();
    test_four_beat();
    test_max_len();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lbsmm_dot_ctrl.md
Name: lbsmm_dot_ctrl

Overview:
Sequencer that streams 4-bit sign-magnitude operand pairs through one shared LBSMM multiplier and accumulates the products into a dot-product sum.
- Accepts operands on a valid/ready input stream and issues at most one multiply per cycle.
- Returns each finished vector's sum and beat count on a valid/ready output stream.
- Sits between the operand-fetch logic and the result writeback in the quantized-inference datapath.

Parameters:
ACC_W, 16, accumulator and out_sum width in bits, two's complement; legal range 8 to 32.
MAX_LEN, 64, maximum number of beats per vector; the vector is force-closed when this count is reached.
CNT_W, $clog2(MAX_LEN+1), width of out_count.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  controller can accept a beat
in_a  in  4  operand A, SM format: [3] sign, [2:0] magnitude
in_b  in  4  operand B, same format
in_last  in  1  beat is the final beat of the vector
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_sum  out  ACC_W  dot-product sum, two's complement
out_count  out  CNT_W  number of beats accumulated
out_ovf  out  1  sticky flag: signed overflow occurred during this vector

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=ACCUM, in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ovf=0, and all operand/product registers 0.
- Reset mid-vector discards all partial state. No result is emitted for the interrupted vector.
- Multiplier instance: one LBSMM, driven from the registered operand pair op_a/op_b.
- Product decode: LBSMM result is 7-bit sign-magnitude, [6] sign and [5:0] magnitude, range 0..49.
  - Convert to two's complement: value = (sign && mag!=0) ? -mag : mag.
  - Sign-extend to ACC_W bits before adding.
- Negative zero: SM 1000 is treated as zero. Any product whose magnitude is 0 contributes 0 regardless of its sign bit.
- Pipeline:
  - A beat is accepted at edge k when in_valid && in_ready. At edge k, in_a/in_b load into op_a/op_b and op_vld is set.
  - At edge k+1, acc <= acc + product and count <= count + 1.
  - Throughput is 1 beat per cycle while in ACCUM.
- State ACCUM: in_ready=1.
  - A beat accepted with in_last=1 moves the FSM to DRAIN.
  - A beat that brings the accepted count to MAX_LEN also moves the FSM to DRAIN, with in_last treated as 1.
- State DRAIN: in_ready=0. Lasts exactly one cycle, during which the final product is added. Then go to DONE.
- State DONE: out_valid=1 and in_ready=0. out_sum, out_count and out_ovf are held stable until out_valid && out_ready.
  - On that handshake edge: acc, count and ovf clear to 0, and the FSM returns to ACCUM.
- Latency: the last beat is accepted at edge k, and out_valid is first high after edge k+2.
- Minimum vector-to-vector gap is 0 idle input cycles beyond the DRAIN/DONE cycles.
- Overflow: acc wraps modulo 2^ACC_W. ovf is set when the operands of an add share a sign and the sum's sign differs. Once set, it holds until the result handshake.
- An in_valid low gap inside a vector is legal; the accumulator holds its value.

Decomposition:
- Shared package lbsmm_pkg holds:
  - SM field constants: SM_W=4, SM_SIGN_BIT=3, MAG_W=3.
  - Product constants: PROD_W=7, PROD_SIGN_BIT=6.
  - Function sm7_to_tc(prod, width).
  - FSM state enum {ACCUM, DRAIN, DONE}.
- Sub-module: the existing LBSMM, instantiated once inside lbsmm_dot_ctrl. No other sub-modules.

Test Plan:
1. Single beat: A=1011 (-3), B=0101 (+5), in_last=1 -> out_sum=0xFFF1 (-15), out_count=1, out_ovf=0; out_valid first high after the second edge following acceptance.
2. Four-beat vector: (7,7), (-7,7), (2,-3), (-0 = 1000, 5) with last on the fourth -> out_sum=-6 (0xFFFA), out_count=4.
3. MAX_LEN cap: MAX_LEN=8, eight beats of (7,7), in_last never asserted -> out_sum=392, out_count=8; in_ready drops after the 8th acceptance; the 9th pending beat waits for the next vector.
4. Overflow: ACC_W=8, three beats of (7,7) -> out_sum=0x93 (wrapped 147), out_ovf=1; the next vector of (1,1) -> out_sum=1, out_ovf=0.
5. Backpressure: out_ready held low for 5 cycles in DONE -> out_valid, out_sum and out_count stable, in_ready=0 throughout; out_ready=1 -> the next vector's first beat is accepted on the following cycle.
6. Reset mid-vector: after 3 beats of (2,2), assert rst for 1 cycle -> out_valid=0 and in_ready=1; then one beat (1,-1) with last -> out_sum=-1, out_count=1.
